// File: rtl/jstk_pkg.sv
// jstk_pkg: shared constants, FSM state type and TX word packing for the joystick SPI responder.
package jstk_pkg;
    localparam logic [7:0] cmd_set_led_c = 8'h84;
    localparam int frame_bytes_c = 5;
    typedef enum logic {IDLE, SHIFT} state_e;
    function automatic logic [39:0] pack_tx(input logic [9:0] x, input logic [9:0] y, input logic [1:0] b);
        return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 6'b0, b};
    endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-FF synchroniser with registered rise/fall pulses; resets to the pin's idle level.
module spi_sync_edge #(
    parameter logic idle_p = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);
    logic [2:0] s_q;
    logic       rise_q, fall_q;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s_q    <= {3{idle_p}};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s_q    <= {s_q[1:0], d_i};
            rise_q <= s_q[1] & ~s_q[2];
            fall_q <= ~s_q[1] & s_q[2];
        end
    end
    assign sync_o = s_q[1];
    assign rise_o = rise_q;
    assign fall_o = fall_q;
endmodule

// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder: SPI mode-0 responder emulating a PmodJSTK2; serves position/buttons and
// decodes the 5-byte command frame to recover the RGB LED colour.
module jstk_spi_responder
    import jstk_pkg::*;
#(
    parameter int frame_bytes_p = frame_bytes_c
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        spi_cs_i,
    input  logic        spi_sck_i,
    input  logic        spi_sd_i,
    output logic        spi_sd_o,
    input  logic [9:0]  position_x_i,
    input  logic [9:0]  position_y_i,
    input  logic [1:0]  buttons_i,
    output logic [23:0] color_rgb_o,
    output logic        color_valid_o,
    output logic        frame_done_o,
    output logic        frame_error_o
);
    localparam logic [2:0] full_c = 3'(frame_bytes_p);
    localparam logic [2:0] sat_c  = 3'(frame_bytes_p + 1);
    logic        cs_sync, cs_rise, cs_fall, sck_rise, sck_fall, sck_sync;
    logic [1:0]  sd_s_q;
    logic [2:0]  warm_q;
    logic        armed_q;
    state_e      state_q;
    logic [39:0] tx_q;
    logic [6:0]  rx_q;
    logic [2:0]  bit_cnt_q, byte_cnt_q;
    logic [3:0][7:0] slot_q;
    logic        sd_q, done_q, err_q, valid_q;
    logic [23:0] color_q;
    logic [7:0]  rx_byte;
    logic [39:0] tx_word;
    spi_sync_edge #(.idle_p(1'b1)) u_cs (
        .clk_i(clk_i), .reset_i(reset_i), .d_i(spi_cs_i),
        .sync_o(cs_sync), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    spi_sync_edge #(.idle_p(1'b0)) u_sck (
        .clk_i(clk_i), .reset_i(reset_i), .d_i(spi_sck_i),
        .sync_o(sck_sync), .rise_o(sck_rise), .fall_o(sck_fall)
    );
    assign rx_byte = {rx_q, sd_s_q[1]};
    assign tx_word = pack_tx(position_x_i, position_y_i, buttons_i);
    // A CS held low through reset must not start a frame: arm only after seeing CS high
    // once the synchroniser holds real pin data again.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sd_s_q     <= '0;
            warm_q     <= '0;
            armed_q    <= 1'b0;
            state_q    <= IDLE;
            tx_q       <= '0;
            rx_q       <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            slot_q     <= '0;
            sd_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            color_q    <= '0;
        end else begin
            sd_s_q  <= {sd_s_q[0], spi_sd_i};
            warm_q  <= {warm_q[1:0], 1'b1};
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            if (warm_q[2] && cs_sync) armed_q <= 1'b1;
            if (state_q == IDLE) begin
                sd_q <= 1'b0;
                if (cs_fall && armed_q) begin
                    tx_q       <= tx_word;
                    sd_q       <= tx_word[39];
                    bit_cnt_q  <= '0;
                    byte_cnt_q <= '0;
                    state_q    <= SHIFT;
                end
            end else if (cs_rise) begin
                state_q <= IDLE;
                sd_q    <= 1'b0;
                if (byte_cnt_q == full_c && bit_cnt_q == 3'd0) begin
                    done_q <= 1'b1;
                    if (slot_q[0] == cmd_set_led_c) begin
                        color_q <= {slot_q[1], slot_q[2], slot_q[3]};
                        valid_q <= 1'b1;
                    end
                end else begin
                    err_q <= 1'b1;
                end
            end else begin
                if (sck_rise) begin
                    rx_q      <= rx_byte[6:0];
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (byte_cnt_q < 3'd4) slot_q[byte_cnt_q[1:0]] <= rx_byte;
                        byte_cnt_q <= (byte_cnt_q == sat_c) ? byte_cnt_q : byte_cnt_q + 3'd1;
                    end
                end
                if (sck_fall) begin
                    tx_q <= {tx_q[38:0], 1'b0};
                    sd_q <= tx_q[38];
                end
            end
        end
    end
    assign spi_sd_o      = sd_q;
    assign color_rgb_o   = color_q;
    assign color_valid_o = valid_q;
    assign frame_done_o  = done_q;
    assign frame_error_o = err_q;
endmodule

// File: tb/tb_jstk_spi_responder.sv
// tb_jstk_spi_responder: directed SPI-initiator bench for the joystick responder.
module tb_jstk_spi_responder;
    logic        clk = 1'b0;
    logic        reset_i, spi_cs_i, spi_sck_i, spi_sd_i;
    logic        spi_sd_o, color_valid_o, frame_done_o, frame_error_o;
    logic [9:0]  position_x_i, position_y_i;
    logic [1:0]  buttons_i;
    logic [23:0] color_rgb_o;
    logic [7:0]  mosi [0:5];
    logic [7:0]  miso [0:5];
    int checks = 0, errors = 0;
    int done_n = 0, valid_n = 0, err_n = 0, both_n = 0;
    int done_s, valid_s, err_s, both_s;

    jstk_spi_responder dut (
        .clk_i(clk), .reset_i(reset_i), .spi_cs_i(spi_cs_i), .spi_sck_i(spi_sck_i),
        .spi_sd_i(spi_sd_i), .spi_sd_o(spi_sd_o), .position_x_i(position_x_i),
        .position_y_i(position_y_i), .buttons_i(buttons_i), .color_rgb_o(color_rgb_o),
        .color_valid_o(color_valid_o), .frame_done_o(frame_done_o), .frame_error_o(frame_error_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        done_n  += int'(frame_done_o);
        valid_n += int'(color_valid_o);
        err_n   += int'(frame_error_o);
        both_n  += int'(frame_done_o & color_valid_o);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        done_s = done_n; valid_s = valid_n; err_s = err_n; both_s = both_n;
    endtask

    task automatic chk_pulses(input string tag, input int ed, input int ev, input int ee);
        chk({tag, "_done"},  32'(done_n - done_s), 32'(ed));
        chk({tag, "_valid"}, 32'(valid_n - valid_s), 32'(ev));
        chk({tag, "_err"},   32'(err_n - err_s), 32'(ee));
    endtask

    task automatic cs_low();
        spi_cs_i = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic bits(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            spi_sd_i = mosi[i/8][7-(i%8)];
            repeat (6) @(negedge clk);
            spi_sck_i = 1'b1;
            miso[i/8][7-(i%8)] = spi_sd_o;
            repeat (6) @(negedge clk);
            spi_sck_i = 1'b0;
        end
    endtask

    task automatic cs_high();
        repeat (6) @(negedge clk);
        spi_cs_i = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic set_mosi(input logic [47:0] v);
        for (int i = 0; i < 6; i++) mosi[i] = v[47-8*i -: 8];
        for (int i = 0; i < 6; i++) miso[i] = 8'hxx;
    endtask

    initial begin
        reset_i = 1'b1; spi_cs_i = 1'b1; spi_sck_i = 1'b0; spi_sd_i = 1'b0;
        position_x_i = 10'h2A5; position_y_i = 10'h13C; buttons_i = 2'b01;
        repeat (3) @(negedge clk);
        chk("rst_sd", 32'(spi_sd_o), 32'd0);
        chk("rst_color", 32'(color_rgb_o), 32'h0);
        chk("rst_pulses", 32'({color_valid_o, frame_done_o, frame_error_o}), 32'd0);
        reset_i = 1'b0;
        repeat (6) @(negedge clk);

        // LED command with exact completion latency
        set_mosi(48'h84FF00000000); snap();
        cs_low(); bits(0, 40);
        repeat (6) @(negedge clk);
        spi_cs_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("led_pre_done", 32'(frame_done_o), 32'd0);
        chk("led_pre_color", 32'(color_rgb_o), 32'h0);
        @(negedge clk);
        chk("led_done_lat", 32'(frame_done_o), 32'd1);
        chk("led_valid_lat", 32'(color_valid_o), 32'd1);
        chk("led_color", 32'(color_rgb_o), 32'hFF0000);
        repeat (6) @(negedge clk);
        chk("led_miso0", 32'(miso[0]), 32'hA5);
        chk("led_miso1", 32'(miso[1]), 32'h02);
        chk("led_miso2", 32'(miso[2]), 32'h3C);
        chk("led_miso3", 32'(miso[3]), 32'h01);
        chk("led_miso4", 32'(miso[4]), 32'h01);
        chk_pulses("led", 1, 1, 0);
        chk("led_both", 32'(both_n - both_s), 32'd1);

        // Non-LED command
        set_mosi(48'hC01122330000); snap();
        cs_low(); bits(0, 40); cs_high();
        chk_pulses("nonled", 1, 0, 0);
        chk("nonled_color", 32'(color_rgb_o), 32'hFF0000);

        // Short frame: 3 bytes
        set_mosi(48'h8400FF000000); snap();
        cs_low(); bits(0, 24); cs_high();
        chk_pulses("short", 0, 0, 1);
        chk("short_color", 32'(color_rgb_o), 32'hFF0000);

        // Partial byte: 4 bytes + 3 bits
        set_mosi(48'h8400FF00E000); snap();
        cs_low(); bits(0, 35); cs_high();
        chk_pulses("partial", 0, 0, 1);
        chk("partial_color", 32'(color_rgb_o), 32'hFF0000);

        // Over-long frame: 6 bytes, MISO idles at 0 in byte 6
        set_mosi(48'h840000FF0000); snap();
        cs_low(); bits(0, 48); cs_high();
        chk_pulses("long", 0, 0, 1);
        chk("long_miso5", 32'(miso[5]), 32'h00);
        chk("long_color", 32'(color_rgb_o), 32'hFF0000);

        // Mid-frame reset during byte 2, while MISO is driving a 1
        set_mosi(48'h84FF00000000); snap();
        cs_low(); bits(0, 14);
        repeat (6) @(negedge clk);
        chk("mid_sd_before", 32'(spi_sd_o), 32'd1);
        reset_i = 1'b1;
        #1;
        chk("mid_sd_reset", 32'(spi_sd_o), 32'd0);
        chk("mid_color_reset", 32'(color_rgb_o), 32'h0);
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        bits(14, 26); cs_high();
        chk_pulses("mid", 0, 0, 0);
        chk("mid_color_after", 32'(color_rgb_o), 32'h0);
        set_mosi(48'h840000FF0000); snap();
        cs_low(); bits(0, 40); cs_high();
        chk_pulses("post_reset", 1, 1, 0);
        chk("post_reset_color", 32'(color_rgb_o), 32'h0000FF);

        // Position captured at CS fall, not when it changes mid-frame
        set_mosi(48'h001122334400); snap();
        cs_low(); bits(0, 4);
        position_x_i = 10'h15A;
        bits(4, 36); cs_high();
        chk("snap_miso0", 32'(miso[0]), 32'hA5);
        chk("snap_miso1", 32'(miso[1]), 32'h02);
        chk_pulses("snap", 1, 0, 0);
        chk("snap_color", 32'(color_rgb_o), 32'h0000FF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
